// File: rtl/posit_dsr_pipe_if.sv
// posit_dsr_pipe_if: operand and result valid/ready channels of posit_dsr_pipe.
// master: upstream/downstream side (drives in_* and out_ready); slave: the shifter.
// in_ready is combinational from out_ready inside the shifter; all out_* are registered.
interface posit_dsr_pipe_if #(
  parameter int N     = 16,
  parameter int S     = 4,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [S-1:0]     in_shamt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_lost;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_lost, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_lost, out_tag
  );
endinterface

// File: rtl/posit_dsr_pipe.sv
// posit_dsr_pipe: pipelined barrel shifter (logical/arith right, left) with sticky lost-bit flag and tag.
// Latency S cycles, one operation per cycle; outputs come straight from the last stage register.
// Global stall: when out_valid && !out_ready every stage holds and in_ready drops (combinational from out_ready).
// Ports: clk, rst_n (synchronous, active-low); bus (slave) carries in_valid/in_ready/in_data/in_shamt/
//   in_mode/in_tag and out_valid/out_ready/out_data/out_lost/out_tag. in_mode 00 lsr, 01 asr, 10 lsl, 11 = 00.
module posit_dsr_pipe #(
  parameter int N     = 16,
  parameter int S     = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  posit_dsr_pipe_if.slave  bus
);

  // One pipeline slot. Mode is reduced to a left flag and the fill bit, so the
  // reserved encoding naturally behaves as a logical right shift.
  typedef struct packed {
    logic             vld;
    logic             left;
    logic             fill;
    logic             lost;
    logic [TAG_W-1:0] tag;
    logic [S-1:0]     shamt;
    logic [N-1:0]     data;
  } stage_t;

  logic   stall;
  stage_t cap;
  stage_t out_q;
  stage_t link [S+1];

  // Operand as captured at the pipe entry; the arithmetic fill is the operand's sign.
  always_comb begin
    cap       = '0;
    cap.vld   = bus.in_valid;
    cap.left  = (bus.in_mode == 2'b10);
    cap.fill  = (bus.in_mode == 2'b01) & bus.in_data[N-1];
    cap.lost  = 1'b0;
    cap.tag   = bus.in_tag;
    cap.shamt = bus.in_shamt;
    cap.data  = bus.in_data;
  end

  assign link[0] = cap;

  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int AMT = 1 << k;

    stage_t stg_d;
    stage_t stg_q;

    if (AMT >= N) begin : g_flush
      // Every bit leaves the word. Fill copies inserted by earlier levels are
      // zero for logical/left shifts, and for arithmetic shifts the original
      // sign bit is still present and is itself shifted out, so OR of the
      // whole word is exactly the lost contribution.
      always_comb begin
        stg_d = link[k];
        if (link[k].shamt[k]) begin
          stg_d.lost = link[k].lost | (|link[k].data);
          stg_d.data = {N{link[k].fill}};
        end
      end
    end else begin : g_shift
      always_comb begin
        stg_d = link[k];
        if (link[k].shamt[k]) begin
          if (link[k].left) begin
            stg_d.lost = link[k].lost | (|link[k].data[N-1 -: AMT]);
            stg_d.data = link[k].data << AMT;
          end else begin
            stg_d.lost = link[k].lost | (|link[k].data[AMT-1:0]);
            stg_d.data = (link[k].data >> AMT) |
                         ({N{link[k].fill}} & ~({N{1'b1}} >> AMT));
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stg_q <= '0;
      end else if (!stall) begin
        stg_q <= stg_d;
      end
    end

    assign link[k+1] = stg_q;
  end

  assign out_q = link[S];

  // Bubbles advance like data, so the only place a hole can block is the output.
  assign stall        = out_q.vld & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  assign bus.out_valid = out_q.vld;
  assign bus.out_data  = out_q.data;
  assign bus.out_lost  = out_q.lost;
  assign bus.out_tag   = out_q.tag;

  // Control fields have no further use once the last level is applied.
  logic unused_out;
  assign unused_out = ^{out_q.left, out_q.fill, out_q.shamt};

endmodule

// File: tb/tb_posit_dsr_pipe.sv
// tb_posit_dsr_pipe: scoreboard bench for posit_dsr_pipe (N=16, S=4).
// Driver pushes expected results on acceptance; monitor pops on each output transfer.
// Monitor also checks in_ready, output hold while stalled, and cycle latency.
module tb_posit_dsr_pipe;
  localparam int N  = 16;
  localparam int S  = 4;
  localparam int TW = 8;

  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  posit_dsr_pipe_if #(.N(N), .S(S), .TAG_W(TW)) bus ();

  posit_dsr_pipe #(.N(N), .S(S), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0]  d;
    logic          lost;
    logic [TW-1:0] tag;
    int            acc;
    int            stl;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;
  bit   sweep_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: shift as multiplication / floor division by 2^s on the operand's
  // numeric value; lost is whatever the arithmetic discards.
  function automatic logic [N:0] model(input logic [N-1:0] d, input int s, input logic [1:0] m);
    longint p, v, r, msk;
    logic   lost;
    p   = longint'(1) << s;
    msk = (longint'(1) << N) - 1;
    if (m == 2'b10) begin
      v    = longint'(d) * p;
      r    = v & msk;
      lost = (v > msk);
    end else begin
      v = longint'(d);
      if (m == 2'b01 && d[N-1]) v = v - (longint'(1) << N);
      if (v >= 0) r = v / p;
      else        r = -((-v + p - 1) / p);
      r    = r & msk;
      lost = ((longint'(d) % p) != 0);
    end
    return {lost, r[N-1:0]};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [N-1:0] d, input logic [S-1:0] sh, input logic [1:0] m,
                      input logic [TW-1:0] tg, input logic [N-1:0] ed, input logic el);
    int   n;
    exp_t e;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_mode  = m;
    bus.in_tag   = tg;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles, required 1", n);
    end else begin
      e.d    = ed;
      e.lost = el;
      e.tag  = tg;
      e.acc  = cyc;
      e.stl  = stall_cnt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [S-1:0] sh, input logic [1:0] m);
    logic [N-1:0]  d;
    logic [TW-1:0] t;
    logic [N:0]    r;
    d = N'($urandom);
    t = TW'($urandom);
    r = model(d, int'(sh), m);
    send(d, sh, m, t, r[N-1:0], r[N]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    #1;
  endtask

  // Monitor
  bit            held_vld;
  logic [N-1:0]  held_d;
  logic          held_l;
  logic [TW-1:0] held_t;

  always @(negedge clk) begin
    exp_t e;
    bit   stalled;
    if (rst_n) begin
      stalled = bus.out_valid && !bus.out_ready;
      check("in_ready", 32'(bus.in_ready), 32'(!stalled));
      if (bus.out_valid) begin
        if (held_vld) begin
          check("hold_data", 32'(bus.out_data), 32'(held_d));
          check("hold_lost", 32'(bus.out_lost), 32'(held_l));
          check("hold_tag",  32'(bus.out_tag),  32'(held_t));
        end else if (q.size() != 0) begin
          check("latency", 32'(cyc), 32'(q[0].acc + S + stall_cnt - q[0].stl));
        end
        if (bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: data %0h tag %0h emerged, required none", bus.out_data, bus.out_tag);
          end else begin
            e = q.pop_front();
            check("data", 32'(bus.out_data), 32'(e.d));
            check("lost", 32'(bus.out_lost), 32'(e.lost));
            check("tag",  32'(bus.out_tag),  32'(e.tag));
          end
        end
      end
      held_vld = stalled;
      held_d   = bus.out_data;
      held_l   = bus.out_lost;
      held_t   = bus.out_tag;
      if (stalled) stall_cnt++;
    end else begin
      held_vld = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_mode   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    sweep_done    = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data),  0);
    check("rst_out_lost",  32'(bus.out_lost),  0);
    check("rst_out_tag",   32'(bus.out_tag),   0);
    check("rst_in_ready",  32'(bus.in_ready),  1);
    @(posedge clk);
    #1;

    // Directed cases
    send(16'h8001, 4'd1, 2'b00, 8'h5A, 16'h4000, 1'b1);
    drain();
    send(16'h8000, 4'd15, 2'b01, 8'h11, 16'hFFFF, 1'b0);
    send(16'h0001, 4'd15, 2'b10, 8'h22, 16'h8000, 1'b0);
    drain();
    send(16'h00F0, 4'd12, 2'b10, 8'h33, 16'h0000, 1'b1);
    send(16'h000F, 4'd12, 2'b10, 8'h44, 16'hF000, 1'b0);
    drain();

    // Backpressure: 3-cycle out_ready drop in the middle of an 8-op stream
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)));
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) send_rand(4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      check("flush_out_valid", 32'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    // Low nibble 4 is shifted out, so the lost flag is set.
    send(16'h1234, 4'd4, 2'b00, 8'h77, 16'h0123, 1'b1);
    drain();

    // Sweep every shift amount and mode (reserved included) under random backpressure
    fork
      begin
        for (int rep = 0; rep < 3; rep++) begin
          for (int s = 0; s < 16; s++) begin
            for (int m = 0; m < 4; m++) begin
              if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
              end
              send_rand(4'(s), 2'(m));
            end
          end
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
